// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states and default line parameters.
// The transmit and receive stages both import this package.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Request/completion handshake between the transmit address sequencer (master)
// and the UART transmit serializer (slave).
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
) ();

    logic                 Tx_start;
    logic [DATA_BITS-1:0] Tx_data;
    logic                 Busy;
    logic                 Tx_tick;

    modport master (
        output Tx_start,
        output Tx_data,
        input  Busy,
        input  Tx_tick
    );

    modport slave (
        input  Tx_start,
        input  Tx_data,
        output Busy,
        output Tx_tick
    );

endinterface

// File: rtl/uart_baud_counter.sv
// Baud-rate divider: counts clock cycles within one serial bit while enabled
// and flags the final cycle of each bit.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic Clk,
    input  logic Rst,
    input  logic en,
    output logic bit_done
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // Holding the count at zero while disabled makes it restart cleanly when en rises.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values and simulation matches the synthesized flops.
        if (Rst || !en) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign bit_done = en && (count == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: accepts a byte on the handshake interface, shifts it out
// LSB first on Tx and pulses Tx_tick in the last cycle of the stop bit.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                  Clk,
    input  logic                  Rst,
    uart_tx_serializer_if.slave   tx_if,
    output logic                  Tx
);

    localparam int               IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e          state, state_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic                 tx_next;
    logic                 bit_done;
    logic                 baud_en;

    assign baud_en = (state != IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .Clk      (Clk),
        .Rst      (Rst),
        .en       (baud_en),
        .bit_done (bit_done)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            Tx      <= 1'b1;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_idx <= bit_idx_next;
            Tx      <= tx_next;
        end
    end

    always_comb begin
        // NOTE: the hold-value default ahead of the case keeps every path
        // assigned, so no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (tx_if.Tx_start)                    state_next = START;
            START:   if (bit_done)                          state_next = DATA;
            DATA:    if (bit_done && bit_idx == LAST_IDX)   state_next = STOP;
            STOP:    if (bit_done)                          state_next = IDLE;
            default:                                        state_next = IDLE;
        endcase
    end

    always_comb begin
        shreg_next   = shreg;
        bit_idx_next = bit_idx;
        tx_next      = 1'b1;

        tx_if.Busy    = (state != IDLE);
        // Gated by Rst so an abandoned frame never reports completion.
        tx_if.Tx_tick = (state == STOP) && bit_done && !Rst;

        case (state)
            IDLE: begin
                if (tx_if.Tx_start) begin
                    shreg_next   = tx_if.Tx_data;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shreg_next   = shreg >> 1;
                    bit_idx_next = (bit_idx == LAST_IDX) ? '0 : bit_idx + IDX_W'(1);
                end
            end
            default: ;
        endcase

        // Tx is registered, so the line level is chosen from the state being entered.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLKS_PER_BIT=4, DATA_BITS=8.
// Outputs are observed on the falling edge; "cycle k" is the value sampled at rising edge k.
module tb_uart_tx_serializer;

    localparam int C     = 4;
    localparam int D     = 8;
    localparam int FRAME = C * (D + 2);
    localparam int N_SEQ = 32;

    logic Clk = 1'b0;
    logic Rst;
    logic Tx;

    int checks = 0;
    int errors = 0;

    uart_tx_serializer_if #(.DATA_BITS(D)) tx_if ();

    uart_tx_serializer #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (D)
    ) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .tx_if (tx_if),
        .Tx    (Tx)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge Clk);
    endtask

    // Expected line level k cycles after the accept edge of a frame carrying d.
    function automatic logic exp_line(input logic [7:0] d, input int k);
        int slot;
        if (k < 1 || k > FRAME) return 1'b1;
        slot = (k - 1) / C;
        if (slot == 0) return 1'b0;
        if (slot <= D) return d[slot-1];
        return 1'b1;
    endfunction

    // Drives a request so it is sampled at the next edge (A); returns at cycle A+1.
    task automatic start_pulse(input logic [7:0] d);
        tx_if.Tx_data  = d;
        tx_if.Tx_start = 1'b1;
        step();
        tx_if.Tx_start = 1'b0;
        tx_if.Tx_data  = ~d;
    endtask

    task automatic test_reset();
        Rst            = 1'b1;
        tx_if.Tx_start = 1'b0;
        tx_if.Tx_data  = 8'h00;
        step();
        step();
        Rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step();
            checks++;
            if (Tx !== 1'b1 || tx_if.Busy !== 1'b0 || tx_if.Tx_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: Tx=%b Busy=%b Tx_tick=%b, required 1 0 0",
                         k, Tx, tx_if.Busy, tx_if.Tx_tick);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] seq;
        logic       exp_tx;
        seq = 10'b11_0100_1010;
        start_pulse(8'hA5);
        for (int k = 1; k <= FRAME + 1; k++) begin
            exp_tx = (k <= FRAME) ? seq[(k-1)/C] : 1'b1;
            checks++;
            if (Tx !== exp_tx || tx_if.Busy !== (k <= FRAME) || tx_if.Tx_tick !== (k == FRAME)) begin
                errors++;
                $display("FAIL single_frame A+%0d: Tx=%b Busy=%b Tx_tick=%b, required %b %b %b",
                         k, Tx, tx_if.Busy, tx_if.Tx_tick, exp_tx, k <= FRAME, k == FRAME);
            end
            if (k <= FRAME) step();
        end
    endtask

    task automatic test_ignored_request();
        int ticks = 0;
        start_pulse(8'h00);
        for (int k = 1; k <= FRAME + 1; k++) begin
            if (k == 10) begin
                tx_if.Tx_data  = 8'hFF;
                tx_if.Tx_start = 1'b1;
            end else if (k == 11) begin
                tx_if.Tx_start = 1'b0;
            end
            checks++;
            if (Tx !== exp_line(8'h00, k) || tx_if.Busy !== (k <= FRAME) || tx_if.Tx_tick !== (k == FRAME)) begin
                errors++;
                $display("FAIL ignored_request A+%0d: Tx=%b Busy=%b Tx_tick=%b, required %b %b %b",
                         k, Tx, tx_if.Busy, tx_if.Tx_tick, exp_line(8'h00, k), k <= FRAME, k == FRAME);
            end
            if (k <= FRAME) step();
        end
        for (int k = 0; k < 50; k++) begin
            step();
            if (tx_if.Tx_tick === 1'b1) ticks++;
            checks++;
            if (Tx !== 1'b1 || tx_if.Busy !== 1'b0) begin
                errors++;
                $display("FAIL ignored_request_tail cycle %0d: Tx=%b Busy=%b, required 1 0", k, Tx, tx_if.Busy);
            end
        end
        checks++;
        if (ticks != 0) begin
            errors++;
            $display("FAIL ignored_request_ticks: %0d extra ticks, required 0", ticks);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        tx_if.Tx_data  = 8'h01;
        tx_if.Tx_start = 1'b1;
        step();
        tx_if.Tx_data = 8'h80;
        for (int f = 0; f < 2; f++) begin
            d = (f == 0) ? 8'h01 : 8'h80;
            for (int k = 1; k <= FRAME + 1; k++) begin
                checks++;
                if (Tx !== exp_line(d, k) || tx_if.Busy !== (k <= FRAME) || tx_if.Tx_tick !== (k == FRAME)) begin
                    errors++;
                    $display("FAIL back_to_back frame %0d A+%0d: Tx=%b Busy=%b Tx_tick=%b, required %b %b %b",
                             f, f * (FRAME + 1) + k, Tx, tx_if.Busy, tx_if.Tx_tick,
                             exp_line(d, k), k <= FRAME, k == FRAME);
                end
                if (f == 0 || k <= FRAME) step();
            end
            // Second frame accepted at A+41; its start bit is seen from A+42.
            if (f == 0) tx_if.Tx_start = 1'b0;
        end
    endtask

    task automatic test_mid_frame_reset();
        int ticks = 0;
        start_pulse(8'h5A);
        for (int k = 1; k <= 15; k++) begin
            if (k == 15) Rst = 1'b1;
            checks++;
            if (Tx !== exp_line(8'h5A, k) || tx_if.Busy !== 1'b1 || tx_if.Tx_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_partial A+%0d: Tx=%b Busy=%b Tx_tick=%b, required %b 1 0",
                         k, Tx, tx_if.Busy, tx_if.Tx_tick, exp_line(8'h5A, k));
            end
            step();
        end
        Rst = 1'b0;
        checks++;
        if (Tx !== 1'b1 || tx_if.Busy !== 1'b0 || tx_if.Tx_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame A+16: Tx=%b Busy=%b Tx_tick=%b, required 1 0 0",
                     Tx, tx_if.Busy, tx_if.Tx_tick);
        end
        for (int k = 0; k < 45; k++) begin
            step();
            if (tx_if.Tx_tick === 1'b1) ticks++;
            checks++;
            if (Tx !== 1'b1 || tx_if.Busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_quiet cycle %0d: Tx=%b Busy=%b, required 1 0", k, Tx, tx_if.Busy);
            end
        end
        checks++;
        if (ticks != 0) begin
            errors++;
            $display("FAIL reset_no_tick: %0d ticks, required 0", ticks);
        end
        start_pulse(8'h3C);
        for (int k = 1; k <= FRAME + 1; k++) begin
            checks++;
            if (Tx !== exp_line(8'h3C, k) || tx_if.Busy !== (k <= FRAME) || tx_if.Tx_tick !== (k == FRAME)) begin
                errors++;
                $display("FAIL reset_recover A+%0d: Tx=%b Busy=%b Tx_tick=%b, required %b %b %b",
                         k, Tx, tx_if.Busy, tx_if.Tx_tick, exp_line(8'h3C, k), k <= FRAME, k == FRAME);
            end
            if (k <= FRAME) step();
        end
    endtask

    // Sequencer model: address advances on each Tx_tick, memory returns addr[7:0];
    // a line-level receiver decodes each frame at mid-bit.
    task automatic test_sequencer_loop();
        logic [15:0] addr;
        logic [7:0]  rx;
        int          ticks;
        bit          found;
        addr  = 16'h00F0;
        ticks = 0;
        tx_if.Tx_data  = addr[7:0];
        tx_if.Tx_start = 1'b1;
        for (int f = 0; f < N_SEQ; f++) begin
            found = 1'b0;
            for (int w = 0; w < 8 && !found; w++) begin
                step();
                if (Tx === 1'b0) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL seq_start frame %0d: no start bit within 8 cycles, required one", f);
                break;
            end
            step();
            step();
            for (int i = 0; i < D; i++) begin
                repeat (C) step();
                rx[i] = Tx;
            end
            repeat (C) step();
            checks++;
            if (Tx !== 1'b1) begin
                errors++;
                $display("FAIL seq_stop frame %0d: Tx=%b, required 1", f, Tx);
            end
            checks++;
            if (rx !== addr[7:0]) begin
                errors++;
                $display("FAIL seq_data frame %0d: got %h, required %h", f, rx, addr[7:0]);
            end
            found = 1'b0;
            for (int w = 0; w < 6 && !found; w++) begin
                step();
                if (tx_if.Tx_tick === 1'b1) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL seq_tick frame %0d: no Tx_tick within 6 cycles, required one", f);
                break;
            end
            ticks++;
            addr = addr + 16'd1;
            if (ticks == N_SEQ) tx_if.Tx_start = 1'b0;
            else                tx_if.Tx_data  = addr[7:0];
        end
        tx_if.Tx_start = 1'b0;
        checks++;
        if (ticks != N_SEQ) begin
            errors++;
            $display("FAIL seq_fin: %0d ticks before fin, required %0d", ticks, N_SEQ);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (tx_if.Busy !== 1'b0 || tx_if.Tx_tick !== 1'b0 || Tx !== 1'b1) begin
                errors++;
                $display("FAIL seq_after_fin cycle %0d: Tx=%b Busy=%b Tx_tick=%b, required 1 0 0",
                         k, Tx, tx_if.Busy, tx_if.Tx_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_ignored_request();
        test_back_to_back();
        test_mid_frame_reset();
        test_sequencer_loop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit stage that consumes the byte read from sample memory at the address produced by the transmit address sequencer. It emits the byte as an 8N1 serial frame on the board TX pin. At the end of each frame it returns a one-cycle `Tx_tick` completion pulse, which advances the sequencer's address. The block contains a baud-rate divider, a frame state machine and a shift register, all clocked from the single system clock.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200 baud): clock cycles per serial bit. Must be at least 2.
- `DATA_BITS`, default 8: payload bits per frame.

Ports:
- `Clk`, input, 1: system clock. All logic is on the rising edge.
- `Rst`, input, 1: reset. **One clock; reset is synchronous and active-high.**
- `Tx_start`, input, 1: frame request. Sampled only while `Busy`=0.
- `Tx_data`, input, `DATA_BITS`: payload. Latched on the accept cycle.
- `Tx`, output, 1: serial line. Registered. Idle level is 1.
- `Busy`, output, 1: high while a frame is in progress.
- `Tx_tick`, output, 1: one-cycle pulse in the final cycle of the stop bit.

## Operation
- Reset values: `Tx`=1, `Busy`=0, `Tx_tick`=0, state IDLE, counters 0.
- **States:**
  - IDLE: `Tx`=1. Leaves IDLE when `Tx_start` is 1, latching `Tx_data` into the shift register.
  - START: `Tx`=0 for `CLKS_PER_BIT` cycles.
  - DATA: bits are sent LSB first, `DATA_BITS` bits, each held `CLKS_PER_BIT` cycles. The shift register shifts right at each bit boundary.
  - STOP: `Tx`=1 for `CLKS_PER_BIT` cycles. Then returns to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1 and clears on the bit boundary. Width is clog2(`CLKS_PER_BIT`).
- **Bit index:** counts 0..`DATA_BITS`-1. Width is clog2(`DATA_BITS`).
- **Handshake:**
  - `Tx_start` while `Busy`=1 is ignored. It is not queued.
  - `Tx_data` may change freely after the accept cycle.
  - Holding `Tx_start` high continuously produces back-to-back frames separated by exactly one idle cycle.
- **Reset mid-frame:** all outputs take their reset values on the next edge. The partial frame is abandoned and no `Tx_tick` is issued.
- **`Tx_tick`** fires exactly once per completed frame. It never fires in IDLE.

## Timing
Let edge A be the accept edge: `Tx_start`=1 and `Busy`=0 sampled at A. C = `CLKS_PER_BIT`, D = `DATA_BITS`.
- Start bit:
  - `Busy`=1 and `Tx`=0 from cycle A+1.
  - Start bit spans cycles A+1 .. A+C.
- Data bit i (0-based) spans cycles A+1+C(i+1) .. A+C(i+2).
- Stop bit spans cycles A+1+C(D+1) .. A+C(D+2).
- `Tx_tick`=1 only in cycle A+C(D+2), the last stop cycle. `Busy` is still 1 in that cycle.
- `Busy`=0 from cycle A+C(D+2)+1.
  - That cycle is the earliest next accept edge.
  - Frame period under continuous requests is C(D+2)+1 cycles. This is 4341 with the defaults.
- `Tx_start` coinciding with `Tx_tick` is ignored. The sequencer must present the next request after `Busy` falls.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, STOP);
  - default constants `UART_CLKS_PER_BIT`=434 and `UART_DATA_BITS`=8.
  The future `uart_rx` stage imports the same package.
- One sub-module is natural: `uart_baud_counter`.
  - Inputs: `Clk`, `Rst`, `en`.
  - Output: a one-cycle `bit_done` pulse when the count reaches C-1.
  - Its count restarts when `en` rises.
- The frame FSM, shift register and bit index stay in `uart_tx_serializer`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `DATA_BITS`=8.
- **Reset:** after reset, `Tx`=1, `Busy`=0, `Tx_tick`=0. They stay that way for 50 cycles with `Tx_start`=0.
- **Single frame:** `Tx_data`=8'hA5 with a one-cycle `Tx_start` at edge A gives:
  - `Tx` sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, starting at A+1;
  - `Tx_tick` exactly at A+40;
  - `Busy` low at A+41.
- **Ignored request:** pulse `Tx_start` with 8'hFF at A+10 during an 8'h00 frame. The frame stays 8'h00, and no second frame or tick follows.
- **Back-to-back:** hold `Tx_start` high with data 8'h01 then 8'h80. The second start bit begins at A+42, and `Tx_tick` pulses at A+40 and A+81.
- **Mid-frame reset:** assert `Rst` at A+15. From A+16, `Tx`=1 and `Busy`=0, with no `Tx_tick`. A new 8'h3C frame afterwards completes normally.
- **Sequencer loop:** connect to the address sequencer and a memory model holding data = addr[7:0]. Decode all 65536 serial bytes and check them against that model. The sequencer's fin asserts after the 65536th `Tx_tick`.
